ysyx_23060136_forward_unit: RTL and testbench
=============================================

Name: ysyx_23060136_forward_unit

Overview:
Producer side of the EXU1 forwarding interface. It shadows destination tags (GPR rd, CSR address, load flag) of in-flight instructions in EXU2, LSU and WB, plus one retired-writeback buffer. From these it drives forwarded rs1/rs2/csr data, per-operand hazard flags and a load-use stall request back to EXU1. It sits beside the pipeline registers and is the only source of the FORWARD_*_EXU1 signals.

Parameters:
BITS_W, 32, data width
REG_W, 5, GPR index width
CSR_W, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
EXU1_go  in  1  EXU1 instruction transfers to EXU2 this cycle
EXU2_go  in  1  EXU2 transfers to LSU
LSU_go  in  1  LSU transfers to WB
WB_go  in  1  WB retires (register file written this edge)
FORWARD_flush  in  1  kill the instruction in EXU2 (branch redirect)
EXU1_rd, EXU1_rs1, EXU1_rs2  in  REG_W each  EXU1 destination/sources
EXU1_rd_we, EXU1_is_load, EXU1_csr_we  in  1 each  EXU1 writes GPR / is load / writes CSR
EXU1_csr_addr  in  CSR_W  CSR dest address (also source for csr_rs)
EXU2_alu_res, EXU2_csr_wdata  in  BITS_W  EXU2 results
LSU_alu_res, LSU_csr_wdata  in  BITS_W  LSU-stage carried results
LSU_rdata  in  BITS_W  load data
LSU_rdata_valid  in  1  LSU_rdata valid this cycle
WB_data, WB_csr_wdata  in  BITS_W  WB-stage results
FORWARD_rs1_data_EXU1, FORWARD_rs2_data_EXU1, FORWARD_csr_rs_data_EXU1  out  BITS_W  forwarded operands
FORWARD_rs1_hazard_EXU1, FORWARD_rs2_hazard_EXU1, FORWARD_csr_rs_hazard_EXU1  out  1  select forwarded data
FORWARD_stall_EXU1  out  1  EXU1 must not fire

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. All tag valids, retire-buffer valid cleared; all outputs 0 in the cycle after reset is sampled. Reset mid-operation discards all tags.
- Tag entry per stage S in {E2,M,W}: valid, rd, rd_we, is_load, csr_we, csr_addr.
- Advance (per edge): E2 loads EXU1 tag on EXU1_go; else clears on EXU2_go; else holds. M loads E2 on EXU2_go; else clears on LSU_go. W loads M on LSU_go; else clears on WB_go. FORWARD_flush clears E2 valid and takes priority over EXU1_go (EXU1 instruction also killed), does not block E2->M if EXU2_go is also high.
- Retire buffer: on WB_go with W.rd_we and W.rd!=0, capture {rd, WB_data}, valid=1 for the next cycle only; cleared on any cycle without such a WB_go.
- GPR match for source x: x!=0 and entry valid, rd_we, rd==x. Priority E2 > M > W > retire buffer (youngest wins).
- Data: E2 -> EXU2_alu_res; M non-load -> LSU_alu_res; M load -> LSU_rdata; W -> WB_data; buffer -> captured data.
- Stall: any source's winning match is E2 load, or M load with LSU_rdata_valid=0. When stalling, hazard flags still reflect the match; data outputs driven 0. No match -> hazard 0, data 0.
- CSR: match on csr_we and csr_addr==EXU1_csr_addr, priority E2 > M > W; data EXU2/LSU/WB_csr_wdata. Never stalls; no retire buffer for CSRs.
- All data/hazard/stall outputs combinational from registered tags and current inputs (zero-cycle latency); only tags and retire buffer are sequential.
- rd==0 never produces a hazard even if rd_we=1.

Decomposition:
- Shared package/defines: BITS_W, REG_W, CSR_W and a packed fwd_tag_t struct {valid, rd, rd_we, is_load, csr_we, csr_addr}.
- One sub-module natural: ysyx_23060136_forward_match (single-operand priority match/mux for GPR), instantiated for rs1 and rs2.

Test Plan:
- Back-to-back ALU: addi x5 into E2 with EXU2_alu_res=0x10, EXU1_rs1=5 -> rs1_hazard=1, data=0x10, stall=0.
- Load-use: lw x6 in E2, EXU1_rs2=6 -> stall=1; next cycle in M, LSU_rdata_valid=0 -> stall=1; LSU_rdata_valid=1, LSU_rdata=0xDEAD -> stall=0, rs2 data=0xDEAD.
- Priority: x7 written by M (0x1) and E2 (0x2) -> rs1 data=0x2; x0 as rd in E2 with rs1=0 -> hazard=0.
- Retire buffer: WB_go with rd=9, WB_data=0x55 -> next cycle rs1=9 gives hazard=1, data=0x55; following cycle hazard=0.
- CSR: csrw mtvec (0x305) in M with LSU_csr_wdata=0x8000_0000, EXU1_csr_addr=0x305 -> csr_rs_hazard=1, data=0x8000_0000.
- Flush/reset: FORWARD_flush with EXU1_go -> E2 empty, no hazard next cycle; rst asserted with full pipeline -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ysyx_23060136_forward_pkg.sv
// Shared widths, tag layout and match helpers for the EXU1 forwarding producer.
package ysyx_23060136_forward_pkg;

  localparam int BITS_W = 32;
  localparam int REG_W  = 5;
  localparam int CSR_W  = 12;

  // Destination tag shadowed for each in-flight stage (E2, M, W).
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
    logic             csr_we;
    logic [CSR_W-1:0] csr_addr;
  } fwd_tag_t;

  // GPR-only view of a tag, handed to the per-operand matcher.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
  } gpr_tag_t;

  // Which producer won the priority match for one operand.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_E2,
    SRC_M,
    SRC_W,
    SRC_RB
  } fwd_src_e;

  localparam fwd_tag_t TAG_EMPTY = '0;

  function automatic gpr_tag_t gpr_view(input fwd_tag_t t);
    gpr_view = '{valid: t.valid, rd: t.rd, rd_we: t.rd_we, is_load: t.is_load};
  endfunction

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic gpr_hit(input gpr_tag_t t, input logic [REG_W-1:0] src);
    gpr_hit = t.valid && t.rd_we && (t.rd == src) && (src != '0);
  endfunction

  function automatic logic csr_hit(input fwd_tag_t t, input logic [CSR_W-1:0] addr);
    csr_hit = t.valid && t.csr_we && (t.csr_addr == addr);
  endfunction

endpackage

// File: rtl/ysyx_23060136_forward_match.sv
// Single-operand GPR forwarding: youngest-wins priority match and data mux.
module ysyx_23060136_forward_match
  import ysyx_23060136_forward_pkg::*;
#(
  parameter int DATA_W = ysyx_23060136_forward_pkg::BITS_W
) (
  input  logic [REG_W-1:0]  src,
  input  gpr_tag_t          e2,
  input  gpr_tag_t          m,
  input  gpr_tag_t          w,
  input  logic              e2_data_ready,
  input  logic              m_data_ready,
  input  logic              w_data_ready,
  input  logic              rb_valid,
  input  logic [REG_W-1:0]  rb_rd,
  input  logic [DATA_W-1:0] rb_data,
  input  logic [DATA_W-1:0] e2_data,
  input  logic [DATA_W-1:0] m_alu_data,
  input  logic [DATA_W-1:0] m_load_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              hazard,
  output logic [DATA_W-1:0] data,
  output logic              stall
);

  fwd_src_e          sel;
  logic [DATA_W-1:0] raw;

  // Pick the youngest producer of src: E2, then M, then W, then the retire buffer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel = SRC_NONE;
    if (gpr_hit(e2, src))
      sel = SRC_E2;
    else if (gpr_hit(m, src))
      sel = SRC_M;
    else if (gpr_hit(w, src))
      sel = SRC_W;
    else if (rb_valid && (rb_rd == src) && (src != '0))
      sel = SRC_RB;
  end

  // Route the winner's data; a load whose data is not back yet forces a stall.
  always_comb begin
    raw   = '0;
    stall = 1'b0;
    unique case (sel)
      SRC_E2: begin
        raw   = e2_data;
        stall = e2.is_load && !e2_data_ready;
      end
      SRC_M: begin
        raw   = m.is_load ? m_load_data : m_alu_data;
        stall = m.is_load && !m_data_ready;
      end
      SRC_W: begin
        raw   = w_data;
        stall = w.is_load && !w_data_ready;
      end
      SRC_RB: raw = rb_data;
      default: ;
    endcase
  end

  assign hazard = (sel != SRC_NONE);
  // Data is zeroed while stalling so EXU1 never sees a half-formed operand.
  assign data   = stall ? '0 : raw;

endmodule

// File: rtl/ysyx_23060136_forward_unit.sv
// EXU1 forwarding producer: shadows E2/M/W destination tags plus a one-cycle
// retire buffer and drives forwarded operands, hazard flags and a load-use stall.
module ysyx_23060136_forward_unit #(
  parameter int BITS_W = ysyx_23060136_forward_pkg::BITS_W,
  parameter int REG_W  = ysyx_23060136_forward_pkg::REG_W,
  parameter int CSR_W  = ysyx_23060136_forward_pkg::CSR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXU1_go,
  input  logic              EXU2_go,
  input  logic              LSU_go,
  input  logic              WB_go,
  input  logic              FORWARD_flush,
  input  logic [REG_W-1:0]  EXU1_rd,
  input  logic [REG_W-1:0]  EXU1_rs1,
  input  logic [REG_W-1:0]  EXU1_rs2,
  input  logic              EXU1_rd_we,
  input  logic              EXU1_is_load,
  input  logic              EXU1_csr_we,
  input  logic [CSR_W-1:0]  EXU1_csr_addr,
  input  logic [BITS_W-1:0] EXU2_alu_res,
  input  logic [BITS_W-1:0] EXU2_csr_wdata,
  input  logic [BITS_W-1:0] LSU_alu_res,
  input  logic [BITS_W-1:0] LSU_csr_wdata,
  input  logic [BITS_W-1:0] LSU_rdata,
  input  logic              LSU_rdata_valid,
  input  logic [BITS_W-1:0] WB_data,
  input  logic [BITS_W-1:0] WB_csr_wdata,
  output logic [BITS_W-1:0] FORWARD_rs1_data_EXU1,
  output logic [BITS_W-1:0] FORWARD_rs2_data_EXU1,
  output logic [BITS_W-1:0] FORWARD_csr_rs_data_EXU1,
  output logic              FORWARD_rs1_hazard_EXU1,
  output logic              FORWARD_rs2_hazard_EXU1,
  output logic              FORWARD_csr_rs_hazard_EXU1,
  output logic              FORWARD_stall_EXU1
);

  import ysyx_23060136_forward_pkg::*;

  // Tag field widths come from the package; the port widths above must match it.
  fwd_tag_t          exu1_tag;
  fwd_tag_t          e2_q;
  fwd_tag_t          m_q;
  fwd_tag_t          w_q;

  logic              rb_valid_q;
  logic [REG_W-1:0]  rb_rd_q;
  logic [BITS_W-1:0] rb_data_q;
  logic              rb_capture;

  logic              rs1_stall;
  logic              rs2_stall;

  assign exu1_tag = '{valid:    1'b1,
                      rd:       EXU1_rd,
                      rd_we:    EXU1_rd_we,
                      is_load:  EXU1_is_load,
                      csr_we:   EXU1_csr_we,
                      csr_addr: EXU1_csr_addr};

  // Advance the tag shadow alongside the pipeline handshakes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so each stage samples the old value of the one before it.
    if (rst) begin
      e2_q <= TAG_EMPTY;
      m_q  <= TAG_EMPTY;
      w_q  <= TAG_EMPTY;
    end else begin
      // A redirect kills both the E2 instruction and whatever EXU1 was handing over.
      if (FORWARD_flush)
        e2_q.valid <= 1'b0;
      else if (EXU1_go)
        e2_q <= exu1_tag;
      else if (EXU2_go)
        e2_q.valid <= 1'b0;

      // E2 still moves to M on a flush edge; the redirect only concerns younger work.
      if (EXU2_go)
        m_q <= e2_q;
      else if (LSU_go)
        m_q.valid <= 1'b0;

      if (LSU_go)
        w_q <= m_q;
      else if (WB_go)
        w_q.valid <= 1'b0;
    end
  end

  // The register file is written on this edge; the buffer covers EXU1 reading it a cycle later.
  assign rb_capture = WB_go && w_q.valid && w_q.rd_we && (w_q.rd != '0);

  // Retire-buffer valid lives for exactly one cycle after a qualifying retire.
  always_ff @(posedge clk) begin
    if (rst)
      rb_valid_q <= 1'b0;
    else
      rb_valid_q <= rb_capture;
  end

  // Retire-buffer payload; only meaningful while rb_valid_q is set.
  always_ff @(posedge clk) begin
    // NOTE: the payload is left unreset because rb_valid_q alone decides whether it is ever used.
    if (rb_capture) begin
      rb_rd_q   <= w_q.rd;
      rb_data_q <= WB_data;
    end
  end

  ysyx_23060136_forward_match #(.DATA_W(BITS_W)) u_match_rs1 (
    .src           (EXU1_rs1),
    .e2            (gpr_view(e2_q)),
    .m             (gpr_view(m_q)),
    .w             (gpr_view(w_q)),
    .e2_data_ready (1'b0),
    .m_data_ready  (LSU_rdata_valid),
    .w_data_ready  (1'b1),
    .rb_valid      (rb_valid_q),
    .rb_rd         (rb_rd_q),
    .rb_data       (rb_data_q),
    .e2_data       (EXU2_alu_res),
    .m_alu_data    (LSU_alu_res),
    .m_load_data   (LSU_rdata),
    .w_data        (WB_data),
    .hazard        (FORWARD_rs1_hazard_EXU1),
    .data          (FORWARD_rs1_data_EXU1),
    .stall         (rs1_stall)
  );

  ysyx_23060136_forward_match #(.DATA_W(BITS_W)) u_match_rs2 (
    .src           (EXU1_rs2),
    .e2            (gpr_view(e2_q)),
    .m             (gpr_view(m_q)),
    .w             (gpr_view(w_q)),
    .e2_data_ready (1'b0),
    .m_data_ready  (LSU_rdata_valid),
    .w_data_ready  (1'b1),
    .rb_valid      (rb_valid_q),
    .rb_rd         (rb_rd_q),
    .rb_data       (rb_data_q),
    .e2_data       (EXU2_alu_res),
    .m_alu_data    (LSU_alu_res),
    .m_load_data   (LSU_rdata),
    .w_data        (WB_data),
    .hazard        (FORWARD_rs2_hazard_EXU1),
    .data          (FORWARD_rs2_data_EXU1),
    .stall         (rs2_stall)
  );

  assign FORWARD_stall_EXU1 = rs1_stall || rs2_stall;

  // CSR forwarding: youngest writer of the addressed CSR wins; CSR values never stall.
  always_comb begin
    FORWARD_csr_rs_hazard_EXU1 = 1'b0;
    FORWARD_csr_rs_data_EXU1   = '0;
    if (csr_hit(e2_q, EXU1_csr_addr)) begin
      FORWARD_csr_rs_hazard_EXU1 = 1'b1;
      FORWARD_csr_rs_data_EXU1   = EXU2_csr_wdata;
    end else if (csr_hit(m_q, EXU1_csr_addr)) begin
      FORWARD_csr_rs_hazard_EXU1 = 1'b1;
      FORWARD_csr_rs_data_EXU1   = LSU_csr_wdata;
    end else if (csr_hit(w_q, EXU1_csr_addr)) begin
      FORWARD_csr_rs_hazard_EXU1 = 1'b1;
      FORWARD_csr_rs_data_EXU1   = WB_csr_wdata;
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_forward_unit.sv
// Scoreboard bench for the EXU1 forwarding producer.
module tb_ysyx_23060136_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXU1_go, EXU2_go, LSU_go, WB_go, FORWARD_flush;
  logic [4:0]  EXU1_rd, EXU1_rs1, EXU1_rs2;
  logic        EXU1_rd_we, EXU1_is_load, EXU1_csr_we;
  logic [11:0] EXU1_csr_addr;
  logic [31:0] EXU2_alu_res, EXU2_csr_wdata, LSU_alu_res, LSU_csr_wdata;
  logic [31:0] LSU_rdata, WB_data, WB_csr_wdata;
  logic        LSU_rdata_valid;
  logic [31:0] rs1_data, rs2_data, csr_data;
  logic        rs1_hazard, rs2_hazard, csr_hazard, stall;

  typedef struct packed {
    logic        rs1_h;
    logic [31:0] rs1_d;
    logic        rs2_h;
    logic [31:0] rs2_d;
    logic        csr_h;
    logic [31:0] csr_d;
    logic        stall;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  ysyx_23060136_forward_unit dut (
    .clk                        (clk),
    .rst                        (rst),
    .EXU1_go                    (EXU1_go),
    .EXU2_go                    (EXU2_go),
    .LSU_go                     (LSU_go),
    .WB_go                      (WB_go),
    .FORWARD_flush              (FORWARD_flush),
    .EXU1_rd                    (EXU1_rd),
    .EXU1_rs1                   (EXU1_rs1),
    .EXU1_rs2                   (EXU1_rs2),
    .EXU1_rd_we                 (EXU1_rd_we),
    .EXU1_is_load               (EXU1_is_load),
    .EXU1_csr_we                (EXU1_csr_we),
    .EXU1_csr_addr              (EXU1_csr_addr),
    .EXU2_alu_res               (EXU2_alu_res),
    .EXU2_csr_wdata             (EXU2_csr_wdata),
    .LSU_alu_res                (LSU_alu_res),
    .LSU_csr_wdata              (LSU_csr_wdata),
    .LSU_rdata                  (LSU_rdata),
    .LSU_rdata_valid            (LSU_rdata_valid),
    .WB_data                    (WB_data),
    .WB_csr_wdata               (WB_csr_wdata),
    .FORWARD_rs1_data_EXU1      (rs1_data),
    .FORWARD_rs2_data_EXU1      (rs2_data),
    .FORWARD_csr_rs_data_EXU1   (csr_data),
    .FORWARD_rs1_hazard_EXU1    (rs1_hazard),
    .FORWARD_rs2_hazard_EXU1    (rs2_hazard),
    .FORWARD_csr_rs_hazard_EXU1 (csr_hazard),
    .FORWARD_stall_EXU1         (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic rs1_h, input logic [31:0] rs1_d,
                              input logic rs2_h, input logic [31:0] rs2_d,
                              input logic csr_h, input logic [31:0] csr_d,
                              input logic stl);
    mk = '{rs1_h: rs1_h, rs1_d: rs1_d, rs2_h: rs2_h, rs2_d: rs2_d,
           csr_h: csr_h, csr_d: csr_d, stall: stl};
  endfunction

  task automatic expect_out(input string name, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Compare everything queued against the DUT on the falling edge.
  task automatic sample();
    obs_t  e;
    string n;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".rs1_h"}, {31'd0, rs1_hazard}, {31'd0, e.rs1_h});
      check({n, ".rs1_d"}, rs1_data, e.rs1_d);
      check({n, ".rs2_h"}, {31'd0, rs2_hazard}, {31'd0, e.rs2_h});
      check({n, ".rs2_d"}, rs2_data, e.rs2_d);
      check({n, ".csr_h"}, {31'd0, csr_hazard}, {31'd0, e.csr_h});
      check({n, ".csr_d"}, csr_data, e.csr_d);
      check({n, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
    end
  endtask

  task automatic idle();
    EXU1_go = 0; EXU2_go = 0; LSU_go = 0; WB_go = 0; FORWARD_flush = 0;
    EXU1_rd = 0; EXU1_rs1 = 0; EXU1_rs2 = 0;
    EXU1_rd_we = 0; EXU1_is_load = 0; EXU1_csr_we = 0; EXU1_csr_addr = 0;
    EXU2_alu_res = 0; EXU2_csr_wdata = 0; LSU_alu_res = 0; LSU_csr_wdata = 0;
    LSU_rdata = 0; LSU_rdata_valid = 0; WB_data = 0; WB_csr_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                       input logic cwe, input logic [11:0] caddr);
    EXU1_go = 1; EXU1_rd = rd; EXU1_rd_we = we; EXU1_is_load = ld;
    EXU1_csr_we = cwe; EXU1_csr_addr = caddr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state: empty pipeline, nothing forwarded.
    do_reset();
    EXU1_rs1 = 5; EXU1_rs2 = 6; EXU1_csr_addr = 12'h305;
    expect_out("reset", '0);
    sample();

    // Back-to-back ALU from E2.
    idle(); issue(5, 1, 0, 0, 0); tick(); idle();
    EXU1_rs1 = 5; EXU2_alu_res = 32'h10;
    expect_out("alu_e2", mk(1, 32'h10, 0, 0, 0, 0, 0));
    sample();

    // Load-use: E2 load stalls, M load stalls until data valid.
    do_reset(); issue(6, 1, 1, 0, 0); tick(); idle();
    EXU1_rs2 = 6; EXU2_alu_res = 32'h1234;
    expect_out("lu_e2", mk(0, 0, 1, 0, 0, 0, 1));
    sample();
    EXU2_go = 1; tick(); idle();
    EXU1_rs2 = 6; LSU_rdata = 32'hDEAD; LSU_alu_res = 32'hBAD; LSU_rdata_valid = 0;
    expect_out("lu_m_wait", mk(0, 0, 1, 0, 0, 0, 1));
    sample();
    LSU_rdata_valid = 1;
    expect_out("lu_m_ready", mk(0, 0, 1, 32'hDEAD, 0, 0, 0));
    sample();

    // Priority: E2 over M, then M over W, then W alone.
    do_reset(); issue(7, 1, 0, 0, 0); tick(); idle();
    issue(7, 1, 0, 0, 0); EXU2_go = 1; tick(); idle();
    EXU1_rs1 = 7; EXU1_rs2 = 7; EXU2_alu_res = 32'h2; LSU_alu_res = 32'h1;
    expect_out("prio_e2_m", mk(1, 32'h2, 1, 32'h2, 0, 0, 0));
    sample();
    EXU2_go = 1; LSU_go = 1; tick(); idle();
    EXU1_rs1 = 7; EXU2_alu_res = 32'h2; LSU_alu_res = 32'h3; WB_data = 32'h4;
    expect_out("prio_m_w", mk(1, 32'h3, 0, 0, 0, 0, 0));
    sample();
    LSU_go = 1; tick(); idle();
    EXU1_rs1 = 7; LSU_alu_res = 32'h3; WB_data = 32'h4;
    expect_out("prio_w", mk(1, 32'h4, 0, 0, 0, 0, 0));
    sample();

    // x0 as destination never forwards.
    do_reset(); issue(0, 1, 0, 0, 0); tick(); idle();
    EXU1_rs1 = 0; EXU1_rs2 = 0; EXU2_alu_res = 32'h99;
    expect_out("x0", '0);
    sample();

    // Retire buffer: one cycle after WB_go only, holding captured data.
    do_reset(); issue(9, 1, 0, 0, 0); tick(); idle();
    EXU2_go = 1; tick(); idle();
    LSU_go = 1; tick(); idle();
    EXU1_rs1 = 9; WB_data = 32'h55;
    expect_out("rb_w", mk(1, 32'h55, 0, 0, 0, 0, 0));
    sample();
    WB_go = 1; tick(); idle();
    EXU1_rs1 = 9; WB_data = 32'h77;
    expect_out("rb_hit", mk(1, 32'h55, 0, 0, 0, 0, 0));
    sample();
    tick();
    expect_out("rb_expire", '0);
    sample();

    // CSR forwarding from M, and an address miss.
    do_reset(); issue(0, 0, 0, 1, 12'h305); tick(); idle();
    EXU2_go = 1; tick(); idle();
    EXU1_csr_addr = 12'h305; LSU_csr_wdata = 32'h8000_0000;
    EXU2_csr_wdata = 32'h1; WB_csr_wdata = 32'h2;
    expect_out("csr_m", mk(0, 0, 0, 0, 1, 32'h8000_0000, 0));
    sample();
    EXU1_csr_addr = 12'h300;
    expect_out("csr_miss", '0);
    sample();

    // Flush kills the incoming instruction but E2 still advances to M.
    do_reset(); issue(8, 1, 0, 0, 0); tick(); idle();
    issue(5, 1, 0, 0, 0); FORWARD_flush = 1; EXU2_go = 1; tick(); idle();
    EXU1_rs1 = 8; EXU1_rs2 = 5; LSU_alu_res = 32'hABC; EXU2_alu_res = 32'h10;
    expect_out("flush", mk(1, 32'hABC, 0, 0, 0, 0, 0));
    sample();

    // Reset with a full pipeline discards every tag.
    do_reset(); issue(10, 1, 0, 1, 12'h341); tick();
    issue(11, 1, 0, 0, 0); EXU2_go = 1; tick();
    issue(12, 1, 1, 0, 0); EXU2_go = 1; LSU_go = 1; tick(); idle();
    EXU1_rs1 = 11; EXU1_rs2 = 10; EXU1_csr_addr = 12'h341;
    LSU_alu_res = 32'h11; WB_data = 32'h10; WB_csr_wdata = 32'h3;
    expect_out("full", mk(1, 32'h11, 1, 32'h10, 1, 32'h3, 0));
    sample();
    rst = 1; EXU1_go = 1; EXU2_go = 1; LSU_go = 1; WB_go = 1;
    tick();
    rst = 0; EXU1_go = 0; EXU2_go = 0; LSU_go = 0; WB_go = 0;
    EXU1_rs1 = 12;
    expect_out("rst_full", '0);
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
